// File: rtl/imm_operand_encoder_pkg.sv
// ----------------------------------------------------------------------------
// imm_operand_encoder_pkg
//
// Shared definitions for the operand-2 immediate encoder:
//   - controller state enumeration
//   - search / field-width constants
//   - rol32 helper, used to undo the decoder's right-rotation
//
// A constant V is encodable at rotation r when ROR32(imm8, 2r) == V.
// Equivalently, ROL32(V, 2r) has all of bits [31:8] clear and imm8 is its
// low byte. The encoder searches in that form because it gives the
// immediate directly rather than comparing against 256 candidates.
// ----------------------------------------------------------------------------
package imm_operand_encoder_pkg;

    // Number of even rotations searched (rotate_imm = 0 .. NUM_ROT-1).
    localparam int NUM_ROT = 16;
    // Width of the constant being encoded.
    localparam int DATA_W  = 32;
    // Immediate payload width and rotate field width.
    localparam int IMM8_W  = 8;
    localparam int ROT_W   = 4;
    // Width of the assembled shift_operand field {rotate_imm, eight_immed}.
    localparam int SHOP_W  = ROT_W + IMM8_W;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_SEARCH_POS = 2'd1,
        ST_SEARCH_INV = 2'd2,
        ST_DONE       = 2'd3
    } enc_state_t;

    // Rotate left by amt (0..31). The upper half of {v, v} shifted left by
    // amt is exactly the rotated word. This avoids the out-of-range shift
    // that a (v << amt) | (v >> (32 - amt)) form would need at amt = 0.
    function automatic logic [31:0] rol32(input logic [31:0] v,
                                          input logic [4:0]  amt);
        logic [63:0] dbl;
        dbl   = {v, v} << amt;
        rol32 = dbl[63:32];
    endfunction

endpackage : imm_operand_encoder_pkg

// File: rtl/imm_operand_encoder_rot_check.sv
// ----------------------------------------------------------------------------
// imm_rot_check
//
// Purely combinational test of one rotation. It reports whether `value`
// can be written as ROR32({24'b0, imm8}, 2*rot). If it can, it also returns
// the matching imm8.
//
// Ports:
//   value  in   DATA_W  constant under test (already inverted by the caller
//                       for the MVN pass)
//   rot    in   ROT_W   rotate_imm candidate; the real rotation is 2*rot
//   hit    out  1       value is representable at this rotation
//   imm8   out  IMM8_W  eight_immed for this rotation (valid when hit=1)
// ----------------------------------------------------------------------------
module imm_rot_check
    import imm_operand_encoder_pkg::*;
(
    input  logic [DATA_W-1:0] value,
    input  logic [ROT_W-1:0]  rot,
    output logic              hit,
    output logic [IMM8_W-1:0] imm8
);

    logic [DATA_W-1:0]        cand;
    logic [DATA_W-IMM8_W-1:0] upper_nz;

    // Rotating left by 2*rot undoes the decoder's right-rotation. If the
    // constant came from an 8-bit payload, everything above bit 7 is now zero.
    assign cand = rol32(value, {rot, 1'b0});

    // One flag per upper bit, OR-reduced below. This keeps the zero test
    // flat: a single wide NOR over the upper 24 bits.
    generate
        for (genvar gi = 0; gi < DATA_W - IMM8_W; gi++) begin : g_upper
            assign upper_nz[gi] = cand[IMM8_W + gi];
        end
    endgenerate

    assign hit  = ~(|upper_nz);
    assign imm8 = cand[IMM8_W-1:0];

endmodule : imm_rot_check

// File: rtl/imm_operand_encoder.sv
// ----------------------------------------------------------------------------
// imm_operand_encoder
//
// Finds the canonical 12-bit operand-2 immediate {rotate_imm, eight_immed}
// for a 32-bit constant. Each clock checks one rotation, starting at
// rotate_imm = 0, so the first hit is the lowest rotation. If the direct
// search fails and the request allowed it, the search repeats on the
// inverted constant. A hit in that second pass means the constant can be
// built with MVN.
//
// Ports:
//   clk            in   1       clock, rising edge
//   rst            in   1       asynchronous reset, active low
//   in_valid       in   1       request valid
//   in_ready       out  1       request can be accepted (IDLE only)
//   in_value       in   DATA_W  constant to encode
//   allow_inv      in   1       also search ~in_value if the direct search fails
//   out_valid      out  1       result valid, held until out_ready
//   out_ready      in   1       consumer takes the result
//   shift_operand  out  12      {rotate_imm, eight_immed}, 0 when not encodable
//   encodable      out  1       an encoding was found
//   inverted       out  1       the encoding is of ~in_value
//
// Timing, counting the accepting edge as edge 0:
//   direct hit at rotation r    -> out_valid after edge r+1
//   inverted hit at rotation r  -> out_valid after edge NUM_ROT+r+1
//   no encoding                 -> after edge NUM_ROT, or 2*NUM_ROT when the
//                                  inverted pass is enabled
// ----------------------------------------------------------------------------
module imm_operand_encoder #(
    parameter int NUM_ROT = imm_operand_encoder_pkg::NUM_ROT,
    parameter int DATA_W  = imm_operand_encoder_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_value,
    input  logic              allow_inv,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [11:0]       shift_operand,
    output logic              encodable,
    output logic              inverted
);

    import imm_operand_encoder_pkg::*;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    enc_state_t          state_reg, state_next;
    logic [ROT_W-1:0]    rot_cnt_reg;
    logic [DATA_W-1:0]   value_reg;
    logic                inv_en_reg;
    logic [SHOP_W-1:0]   shop_reg;
    logic                encodable_reg;
    logic                inverted_reg;

    // ------------------------------------------------------------------
    // Rotation checker. During SEARCH_INV it sees the inverted constant.
    // In every other state its outputs are ignored.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0]   check_value;
    logic                check_hit;
    logic [IMM8_W-1:0]   check_imm8;
    logic                last_rot;
    logic                accept;

    assign check_value = (state_reg == ST_SEARCH_INV) ? ~value_reg : value_reg;

    // The counter never wraps by itself. Reaching the last rotation always
    // leads to an explicit state change, which also resets or parks it.
    assign last_rot = (rot_cnt_reg == ROT_W'(NUM_ROT - 1));
    assign accept   = (state_reg == ST_IDLE) && in_valid;

    imm_rot_check u_rot_check (
        .value (check_value),
        .rot   (rot_cnt_reg),
        .hit   (check_hit),
        .imm8  (check_imm8)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (in_valid) begin
                    state_next = ST_SEARCH_POS;
                end
            end
            ST_SEARCH_POS: begin
                if (check_hit) begin
                    state_next = ST_DONE;
                end else if (last_rot) begin
                    state_next = inv_en_reg ? ST_SEARCH_INV : ST_DONE;
                end
            end
            ST_SEARCH_INV: begin
                if (check_hit || last_rot) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                // Leaving DONE always passes through IDLE. A new request is
                // accepted one edge later at the earliest.
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output logic
    // ------------------------------------------------------------------
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_reg)
            ST_IDLE: in_ready  = 1'b1;
            ST_DONE: out_valid = 1'b1;
            default: ;
        endcase
    end

    assign shift_operand = shop_reg;
    assign encodable     = encodable_reg;
    assign inverted      = inverted_reg;

    // ------------------------------------------------------------------
    // Datapath: request capture, rotation counter, result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rot_cnt_reg   <= '0;
            value_reg     <= '0;
            inv_en_reg    <= 1'b0;
            shop_reg      <= '0;
            encodable_reg <= 1'b0;
            inverted_reg  <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        value_reg     <= in_value;
                        inv_en_reg    <= allow_inv;
                        rot_cnt_reg   <= '0;
                        // Clear the previous result so a stale encoding is
                        // never visible beside a new request.
                        shop_reg      <= '0;
                        encodable_reg <= 1'b0;
                        inverted_reg  <= 1'b0;
                    end
                end
                ST_SEARCH_POS: begin
                    if (check_hit) begin
                        shop_reg      <= {rot_cnt_reg, check_imm8};
                        encodable_reg <= 1'b1;
                        inverted_reg  <= 1'b0;
                    end else if (!last_rot) begin
                        rot_cnt_reg   <= rot_cnt_reg + 1'b1;
                    end else if (inv_en_reg) begin
                        rot_cnt_reg   <= '0;
                    end else begin
                        shop_reg      <= '0;
                        encodable_reg <= 1'b0;
                        inverted_reg  <= 1'b0;
                    end
                end
                ST_SEARCH_INV: begin
                    if (check_hit) begin
                        shop_reg      <= {rot_cnt_reg, check_imm8};
                        encodable_reg <= 1'b1;
                        inverted_reg  <= 1'b1;
                    end else if (!last_rot) begin
                        rot_cnt_reg   <= rot_cnt_reg + 1'b1;
                    end else begin
                        shop_reg      <= '0;
                        encodable_reg <= 1'b0;
                        inverted_reg  <= 1'b0;
                    end
                end
                default: ;  // DONE: result held stable until accepted
            endcase
        end
    end

endmodule : imm_operand_encoder

// File: tb/tb_imm_operand_encoder.sv
// ----------------------------------------------------------------------------
// tb_imm_operand_encoder
//
// Directed and randomized requests to imm_operand_encoder. Results are
// checked against a brute-force reference. For each rotation, in increasing
// order, the reference tries all 256 immediates and takes the first one
// whose right-rotation equals the constant. The inverted constant is tried
// afterwards when allowed.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_imm_operand_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_value;
    logic        allow_inv;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] shift_operand;
    logic        encodable;
    logic        inverted;

    int n_vec = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    imm_operand_encoder dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_value      (in_value),
        .allow_inv     (allow_inv),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .shift_operand (shift_operand),
        .encodable     (encodable),
        .inverted      (inverted)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ror32(input logic [31:0] x, input int s);
        logic [63:0] d;
        d = {x, x} >> s;
        return d[31:0];
    endfunction

    // Reference: lowest rotation wins, direct pass before inverted pass.
    task automatic ref_model(input logic [31:0] v, input logic ai,
                             output logic [11:0] sop, output logic enc,
                             output logic inv, output int lat);
        logic [31:0] target;
        sop = 12'h000; enc = 1'b0; inv = 1'b0;
        lat = ai ? 32 : 16;
        for (int pass = 0; pass < 2; pass++) begin
            if (!enc && (pass == 0 || ai)) begin
                target = (pass == 1) ? ~v : v;
                for (int r = 0; r < 16; r++) begin
                    for (int imm = 0; imm < 256; imm++) begin
                        if (!enc && ror32(32'(imm), 2 * r) == target) begin
                            enc = 1'b1;
                            inv = (pass == 1);
                            sop = {4'(r), 8'(imm)};
                            lat = pass * 16 + r + 1;
                        end
                    end
                end
            end
        end
    endtask

    // Presents a request at a falling edge. Returns 1ns after the accepting
    // edge (edge 0), with the request withdrawn and the inputs scrambled.
    task automatic start_req(input logic [31:0] v, input logic ai);
        @(negedge clk);
        check("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        in_value  = v;
        allow_inv = ai;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_value  = $urandom;
        allow_inv = 1'($urandom_range(0, 1));
    endtask

    // Call 1ns after edge 0. Counts edges until out_valid (bounded), then
    // compares the latency and the result against the reference.
    task automatic await_result(input logic [31:0] v, input logic ai, input logic do_accept);
        logic [11:0] e_sop;
        logic        e_enc, e_inv;
        int          e_lat, n;
        ref_model(v, ai, e_sop, e_enc, e_inv, e_lat);
        n = 0;
        while (n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (out_valid === 1'b1) break;
        end
        check("latency", 32'(n), 32'(e_lat));
        check("out_valid", 32'(out_valid), 32'd1);
        check("shift_operand", 32'(shift_operand), 32'(e_sop));
        check("encodable", 32'(encodable), 32'(e_enc));
        check("inverted", 32'(inverted), 32'(e_inv));
        check("in_ready_done", 32'(in_ready), 32'd0);
        $display("req value=%h allow_inv=%0d -> sop=%h enc=%0d inv=%0d lat=%0d",
                 v, ai, shift_operand, encodable, inverted, n);
        if (do_accept) begin
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            check("out_valid_after_accept", 32'(out_valid), 32'd0);
            check("in_ready_after_accept", 32'(in_ready), 32'd1);
        end
    endtask

    initial begin
        logic [31:0] rv;
        logic [7:0]  rimm;
        int          rsh;
        logic        rai;

        rst = 1'b0; in_valid = 1'b0; in_value = '0; allow_inv = 1'b0; out_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_shift_operand", 32'(shift_operand), 32'd0);
        check("rst_encodable", 32'(encodable), 32'd0);
        check("rst_inverted", 32'(inverted), 32'd0);
        rst = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Directed cases
        start_req(32'h000000FF, 1'b0); await_result(32'h000000FF, 1'b0, 1'b1);
        start_req(32'hC000003F, 1'b0); await_result(32'hC000003F, 1'b0, 1'b1);
        start_req(32'hFF000000, 1'b0); await_result(32'hFF000000, 1'b0, 1'b1);
        start_req(32'h00000104, 1'b0); await_result(32'h00000104, 1'b0, 1'b1);
        start_req(32'hFFFFFF00, 1'b1); await_result(32'hFFFFFF00, 1'b1, 1'b1);
        start_req(32'hFFFFFF00, 1'b0); await_result(32'hFFFFFF00, 1'b0, 1'b1);
        start_req(32'h00000101, 1'b1); await_result(32'h00000101, 1'b1, 1'b1);
        start_req(32'h00000000, 1'b0); await_result(32'h00000000, 1'b0, 1'b1);
        start_req(32'hFFFFFFFF, 1'b1); await_result(32'hFFFFFFFF, 1'b1, 1'b1);

        // Backpressure: the result stays put, and a new request is ignored
        // until the result has been taken.
        start_req(32'h000000FF, 1'b0); await_result(32'h000000FF, 1'b0, 1'b0);
        in_valid = 1'b1; in_value = 32'hC000003F; allow_inv = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_shift_operand", 32'(shift_operand), 32'h0FF);
            check("bp_encodable", 32'(encodable), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp_release_out_valid", 32'(out_valid), 32'd0);
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);   // back-to-back acceptance
        #1;
        in_valid = 1'b0;
        check("b2b_in_ready", 32'(in_ready), 32'd0);
        await_result(32'hC000003F, 1'b0, 1'b1);

        // Asynchronous reset while a result is pending
        start_req(32'h000000FF, 1'b0); await_result(32'h000000FF, 1'b0, 1'b0);
        #2 rst = 1'b0;
        #1;
        check("arst_done_out_valid", 32'(out_valid), 32'd0);
        check("arst_done_encodable", 32'(encodable), 32'd0);
        check("arst_done_shift_operand", 32'(shift_operand), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Asynchronous reset in the middle of the inverted pass
        start_req(32'h00000101, 1'b1);
        repeat (20) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("arst_inv_out_valid", 32'(out_valid), 32'd0);
        check("arst_inv_encodable", 32'(encodable), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("arst_inv_in_ready", 32'(in_ready), 32'd1);
        start_req(32'h000003FC, 1'b0); await_result(32'h000003FC, 1'b0, 1'b1);

        // Randomized requests
        for (int t = 0; t < 40; t++) begin
            rimm = 8'($urandom);
            rsh  = 2 * $urandom_range(0, 15);
            rai  = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       rv = $urandom;
                1:       rv = ror32({24'h0, rimm}, rsh);
                2:       rv = ~ror32({24'h0, rimm}, rsh);
                default: rv = 32'($urandom_range(0, 1023));
            endcase
            start_req(rv, rai);
            await_result(rv, rai, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule : tb_imm_operand_encoder

// File: doc/imm_operand_encoder.md
Name: imm_operand_encoder

Overview:
- Inverse of the operand-2 immediate decode. Takes a 32-bit constant and searches for a 12-bit immediate shift_operand {rotate_imm[3:0], eight_immed[7:0]} such that the constant equals ROR32({24'b0, eight_immed}, 2*rotate_imm).
- Optionally retries with the bitwise-inverted constant, which enables MOV/MVN substitution.
- Sits in the instruction-build / test-program-generation path, ahead of instruction memory.
- Iterative: one rotation is checked per clock, with valid/ready handshakes on both sides.

Parameters:
- NUM_ROT, 16, number of even rotations searched (rotate_imm range 0..NUM_ROT-1).
- DATA_W, 32, width of the constant.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  encoder can accept a request; high only in IDLE.
- in_value  input  32  constant to encode.
- allow_inv  input  1  if 1, search ~in_value after the direct search fails.
- out_valid  output  1  result valid; held until accepted.
- out_ready  input  1  consumer accepts the result.
- shift_operand  output  12  {rotate_imm, eight_immed}; 0 when not encodable.
- encodable  output  1  an encoding was found.
- inverted  output  1  the encoding is of ~in_value (MVN form).

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, rot_cnt=0, value_q=0, inv_en_q=0.
  - Outputs during reset: out_valid=0, shift_operand=0, encodable=0, inverted=0, in_ready=1 (as soon as reset is released).
  - A reset in any state aborts the search and drops any pending result.
- States: IDLE, SEARCH_POS, SEARCH_INV, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid at a rising edge: latch value_q=in_value and inv_en_q=allow_inv, set rot_cnt=0, go to SEARCH_POS.
- SEARCH_POS (one check per cycle):
  - cand = ROL32(value_q, 2*rot_cnt).
  - Hit when cand[31:8]==0. On a hit, register shift_operand={rot_cnt, cand[7:0]}, encodable=1, inverted=0, go to DONE.
  - Miss with rot_cnt<15: rot_cnt+1.
  - Miss at rot_cnt=15: if inv_en_q, set rot_cnt=0 and go to SEARCH_INV; otherwise set encodable=0, shift_operand=0 and go to DONE.
- SEARCH_INV:
  - Same check on ~value_q. On a hit, set inverted=1.
  - Miss at rot_cnt=15: encodable=0, shift_operand=0, inverted=0, go to DONE.
- Priority: the lowest rot_cnt hit wins, so the encoding is canonical. The direct form always takes priority over the inverted form.
- DONE:
  - out_valid=1; shift_operand, encodable and inverted are stable.
  - On out_ready: go to IDLE with out_valid=0.
  - The earliest next acceptance is the following edge; there is no same-cycle turnaround.
- Latency, counting from the accepting edge as edge 0:
  - Hit at rotation r in the direct pass: out_valid high after edge r+1.
  - Hit at rotation r in the inverted pass: after edge r+17.
  - Failure: after edge 16 (allow_inv=0) or edge 32 (allow_inv=1).
- Input changes on in_value or allow_inv outside IDLE are ignored.
- Rotation arithmetic is modulo 32; rot_cnt wraps only through explicit state change, never by overflow.
- Corner cases: value 0 gives rot 0, imm 0 (hit at r=0). Value 0xFFFFFFFF with allow_inv=1 gives inverted=1, shift_operand=0x000.

Decomposition:
- Shared package (alongside the other datapath constants): state enum, NUM_ROT, IMM8_W=8, ROT_W=4, and a ROL32 function.
- One natural sub-module: imm_rot_check, combinational. Inputs: value, rot. Outputs: hit, imm8.
- The top level holds the FSM, registers and handshake.

Test Plan:
- in_value=0x000000FF, allow_inv=0 -> out_valid after edge 1; shift_operand=0x0FF, encodable=1, inverted=0.
- in_value=0xC000003F -> r=1; shift_operand=0x1FF after edge 2. in_value=0xFF000000 -> shift_operand=0x4FF after edge 5. in_value=0x00000104 -> shift_operand=0xF41 after edge 16.
- in_value=0xFFFFFF00, allow_inv=1 -> after edge 17: encodable=1, inverted=1, shift_operand=0x0FF. Same value with allow_inv=0 -> after edge 16: encodable=0, shift_operand=0.
- in_value=0x00000101, allow_inv=1 -> after edge 32: encodable=0, inverted=0, shift_operand=0x000.
- Backpressure: hold out_ready=0 for 10 cycles -> outputs stable, in_ready=0, a new in_valid is ignored. Raise out_ready -> next edge returns to IDLE; a back-to-back request is accepted on the following edge.
- Drive rst=0 mid-SEARCH_INV (asynchronous, between edges) -> immediate out_valid=0, encodable=0, in_ready=1 after release. A fresh request for 0x3FC then yields shift_operand=0xFFF after edge 16.
